// File: rtl/keypad_encoder_pkg.sv
// Shared types, constants and helpers for the 4x3 matrix keypad encoder.
// Pure definitions; no latency or flow-control implications of their own.
package keypad_encoder_pkg;

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2
    } state_t;

    localparam int          KP_ROWS   = 4;
    localparam int          KP_COLS   = 3;
    localparam logic [3:0]  KEY_NONE  = 4'd0;
    localparam logic [2:0]  COL_RESET = 3'b110;

    // Rotating the single low bit left walks col 0 -> 1 -> 2 -> 0.
    function automatic logic [2:0] col_next(input logic [2:0] col);
        return {col[1:0], col[2]};
    endfunction

    function automatic logic [1:0] col_index(input logic [2:0] col);
        logic [1:0] idx;
        case (col)
            3'b101:  idx = 2'd1;
            3'b011:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [1:0] lowest_low(input logic [3:0] row);
        logic [1:0] idx;
        if (!row[0])      idx = 2'd0;
        else if (!row[1]) idx = 2'd1;
        else if (!row[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        return ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// Keypad pin and key-code bundle: master is the encoder, slave is the board/game side.
// Plain wires, no latency and no backpressure.
interface keypad_encoder_if;
    logic [keypad_encoder_pkg::KP_ROWS-1:0] row;
    logic [keypad_encoder_pkg::KP_COLS-1:0] col;
    logic [3:0]                             out;
    logic                                   key_valid;
    logic                                   key_held;

    modport master (input row, output col, output out, output key_valid, output key_held);
    modport slave  (output row, input col, input out, input key_valid, input key_held);
endinterface

// File: rtl/keypad_encoder_scan_timer.sv
// Dwell timer: free-running counter, tick high on the last cycle of every SCAN_DIV window.
// Tick is combinational from the count register; no backpressure.
module scan_timer #(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == SCAN_DIV - 16'd1);
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/keypad_encoder.sv
// Scans a 4x3 active-low keypad, debounces on dwell ticks and emits a held key code.
// Registered outputs; key_valid one cycle after the accepting tick; no backpressure.
module keypad_encoder
    import keypad_encoder_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV     = 16'd50000,
    parameter logic [3:0]  DEBOUNCE_CNT = 4'd4
) (
    input  logic              clk,
    input  logic              rst,
    keypad_encoder_if.master  kp
);
    logic       tick;
    logic [3:0] sync1_q, sync2_q;
    state_t     state_q;
    logic [2:0] col_q;
    logic [3:0] out_q;
    logic       key_valid_q, key_held_q;
    logic [1:0] cand_row_q, cand_col_q;
    logic [3:0] deb_cnt_q, rel_cnt_q;
    logic [3:0] deb_cnt_d, rel_cnt_d;
    logic       cand_low;

    scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        deb_cnt_d = (deb_cnt_q == 4'hF) ? deb_cnt_q : deb_cnt_q + 4'd1;
        rel_cnt_d = (rel_cnt_q == 4'hF) ? rel_cnt_q : rel_cnt_q + 4'd1;
        cand_low  = ~sync2_q[cand_row_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= kp.row;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_SCAN;
            col_q       <= COL_RESET;
            out_q       <= KEY_NONE;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            cand_row_q  <= 2'd0;
            cand_col_q  <= 2'd0;
            deb_cnt_q   <= 4'd0;
            rel_cnt_q   <= 4'd0;
        end else begin
            key_valid_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    S_SCAN: begin
                        if (&sync2_q) begin
                            col_q <= col_next(col_q);
                        end else begin
                            cand_row_q <= lowest_low(sync2_q);
                            cand_col_q <= col_index(col_q);
                            deb_cnt_q  <= 4'd1;
                            if (DEBOUNCE_CNT <= 4'd1) begin
                                out_q       <= key_code(lowest_low(sync2_q), col_index(col_q));
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                state_q     <= S_HELD;
                            end else begin
                                state_q <= S_DEBOUNCE;
                            end
                        end
                    end
                    S_DEBOUNCE: begin
                        if (cand_low) begin
                            deb_cnt_q <= deb_cnt_d;
                            if (deb_cnt_d >= DEBOUNCE_CNT) begin
                                out_q       <= key_code(cand_row_q, cand_col_q);
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                state_q     <= S_HELD;
                            end
                        end else begin
                            deb_cnt_q <= 4'd0;
                            col_q     <= col_next(col_q);
                            state_q   <= S_SCAN;
                        end
                    end
                    S_HELD: begin
                        // Only the candidate row matters; other rows in this column are ignored.
                        if (!cand_low) begin
                            if (rel_cnt_d >= DEBOUNCE_CNT) begin
                                out_q      <= KEY_NONE;
                                key_held_q <= 1'b0;
                                rel_cnt_q  <= 4'd0;
                                col_q      <= col_next(col_q);
                                state_q    <= S_SCAN;
                            end else begin
                                rel_cnt_q <= rel_cnt_d;
                            end
                        end else begin
                            rel_cnt_q <= 4'd0;
                        end
                    end
                    default: state_q <= S_SCAN;
                endcase
            end
        end
    end

    assign kp.col       = col_q;
    assign kp.out       = out_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_encoder.sv
// Randomised scoreboard bench for keypad_encoder with SCAN_DIV=4, DEBOUNCE_CNT=3.
module tb_keypad_encoder;
    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic [11:0] pressed;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          exp_q[$];
    logic [3:0]  prev_out;
    logic [2:0]  col_seq [3];

    keypad_encoder_if kp_if ();

    keypad_encoder #(.SCAN_DIV(16'd4), .DEBOUNCE_CNT(4'd3)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board model: a row reads low when a pressed key sits in the driven column.
    always_comb begin
        kp_if.row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && !kp_if.col[c]) kp_if.row[r] = 1'b0;
    end

    function automatic int code_of(input int r, input int c);
        return r * 3 + c + 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: every key_valid pulse is matched against the next expected code.
    always @(negedge clk) begin
        if (rst) begin
            prev_out = 4'd0;
        end else begin
            if (kp_if.key_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got code %0d expected no pulse", kp_if.out);
                end else begin
                    chk("pulse_code", kp_if.out, exp_q.pop_front());
                    chk("pulse_held", kp_if.key_held, 1);
                    chk("pulse_prev_out", prev_out, 0);
                end
            end
            prev_out = kp_if.out;
        end
    end

    task automatic wait_pulse(input int target, input string name);
        int n = 0;
        while (pulses < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, pulses, target);
    endtask

    // Release is accepted after three high ticks; sync and tick phase give 11..14 cycles.
    task automatic wait_release(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (kp_if.out != 4'd0 && n < 40);
        chk_rng(name, n, 11, 14);
        chk({name, "_held"}, kp_if.key_held, 0);
    endtask

    task automatic hold_check(input int cycles, input int code, input string name);
        int bad = 0;
        int p0  = pulses;
        repeat (cycles) begin
            @(negedge clk);
            if (kp_if.out != 4'(code) || !kp_if.key_held) bad++;
        end
        chk({name, "_steady"}, bad, 0);
        chk({name, "_one_pulse"}, pulses, p0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int target;
        int r;
        int c;
        int bad;
        int seen;
        col_seq[0] = 3'b110;
        col_seq[1] = 3'b101;
        col_seq[2] = 3'b011;
        pressed = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_col", kp_if.col, 3'b110);
        chk("rst_out", kp_if.out, 0);
        chk("rst_valid", kp_if.key_valid, 0);
        chk("rst_held", kp_if.key_held, 0);

        // Idle scan: column steps every DIV clocks.
        rst = 1'b0;
        chk("scan_col_0", kp_if.col, col_seq[0]);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            chk("scan_col", kp_if.col, col_seq[(j / DIV) % 3]);
        end

        // r1c2 steady press, freeze, release.
        target = pulses + 1;
        exp_q.push_back(code_of(1, 2));
        pressed[code_of(1, 2) - 1] = 1'b1;
        wait_pulse(target, "r1c2_pulse");
        chk("r1c2_col_frozen", kp_if.col, 3'b011);
        hold_check(5 * DIV, 6, "r1c2");
        chk("r1c2_col_still", kp_if.col, 3'b011);
        pressed = '0;
        wait_release("r1c2_release");
        chk("r1c2_col_advance", kp_if.col, 3'b110);
        repeat (DIV) @(negedge clk);
        chk("r1c2_scan_resume", kp_if.col, 3'b101);

        // r0c1 bounce: two low ticks then high.
        seen = 0;
        while (kp_if.col == 3'b101 && seen < 40) begin @(negedge clk); seen++; end
        seen = 0;
        while (kp_if.col != 3'b101 && seen < 40) begin @(negedge clk); seen++; end
        pressed[code_of(0, 1) - 1] = 1'b1;
        repeat (7) @(negedge clk);
        pressed = '0;
        bad = 0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (kp_if.out != 4'd0) bad++;
            if (kp_if.col == 3'b011) seen = 1;
        end
        chk("bounce_out_zero", bad, 0);
        chk("bounce_scan_resume", seen, 1);

        // Two keys in column 0: lowest row wins; then r1c0 alone.
        target = pulses + 1;
        exp_q.push_back(code_of(0, 0));
        pressed[code_of(0, 0) - 1] = 1'b1;
        pressed[code_of(2, 0) - 1] = 1'b1;
        wait_pulse(target, "multi_pulse");
        hold_check(2 * DIV, 1, "multi");
        pressed = '0;
        wait_release("multi_release");
        target = pulses + 1;
        exp_q.push_back(code_of(1, 0));
        pressed[code_of(1, 0) - 1] = 1'b1;
        wait_pulse(target, "r1c0_pulse");
        hold_check(2 * DIV, 4, "r1c0");
        pressed = '0;
        wait_release("r1c0_release");

        // Long hold of r3c2, then a second press.
        target = pulses + 1;
        exp_q.push_back(code_of(3, 2));
        pressed[code_of(3, 2) - 1] = 1'b1;
        wait_pulse(target, "r3c2_pulse");
        hold_check(40 * DIV, 12, "r3c2_long");
        pressed = '0;
        wait_release("r3c2_release");
        target = pulses + 1;
        exp_q.push_back(code_of(3, 2));
        pressed[code_of(3, 2) - 1] = 1'b1;
        wait_pulse(target, "r3c2_second_pulse");
        pressed = '0;
        wait_release("r3c2_second_release");

        // Randomised single-key presses.
        for (int k = 0; k < 6; k++) begin
            r = $urandom_range(3, 0);
            c = $urandom_range(2, 0);
            repeat ($urandom_range(20, 0)) @(negedge clk);
            target = pulses + 1;
            exp_q.push_back(code_of(r, c));
            pressed[code_of(r, c) - 1] = 1'b1;
            wait_pulse(target, "rand_pulse");
            hold_check($urandom_range(10, 2) * DIV, code_of(r, c), "rand");
            pressed = '0;
            wait_release("rand_release");
        end

        // Asynchronous reset while a key is held.
        target = pulses + 1;
        exp_q.push_back(code_of(2, 1));
        pressed[code_of(2, 1) - 1] = 1'b1;
        wait_pulse(target, "r2c1_pulse");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out", kp_if.out, 0);
        chk("arst_held", kp_if.key_held, 0);
        chk("arst_col", kp_if.col, 3'b110);
        repeat (2) @(negedge clk);
        target = pulses + 1;
        exp_q.push_back(code_of(2, 1));
        rst = 1'b0;
        wait_pulse(target, "arst_redebounce_pulse");
        pressed = '0;
        wait_release("arst_release");

        repeat (10) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
